// File: rtl/pc_sequencer.sv
// Next-PC unit for the IF stage: fixed-priority redirect select with alignment trap,
// a one-entry pending buffer for redirects seen while stalled/halted, and halt/step control.
module pc_sequencer #(
  parameter int unsigned         LEN_DATA   = 32,
  parameter logic [LEN_DATA-1:0] RESET_PC   = '0,
  parameter logic [LEN_DATA-1:0] PC_STEP    = LEN_DATA'(4),
  parameter logic [LEN_DATA-1:0] EXC_VECTOR = LEN_DATA'(32'h80),
  parameter int unsigned         ALIGN_BITS = 2,
  parameter int unsigned         CNT_W      = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                jump,
  input  logic [LEN_DATA-1:0] jump_addr,
  input  logic                branch,
  input  logic [LEN_DATA-1:0] branch_addr,
  input  logic                jreg,
  input  logic [LEN_DATA-1:0] jreg_addr,
  input  logic                exc,
  input  logic                halt,
  input  logic                step,
  output logic [LEN_DATA-1:0] pc_out,
  output logic [LEN_DATA-1:0] pc_plus_step,
  output logic                flush,
  output logic                misaligned,
  output logic                halted,
  output logic [CNT_W-1:0]    upd_count
);

  typedef enum logic [1:0] {RUN, HALT, STEP} state_t;

  localparam logic [LEN_DATA-1:0] ALIGN_MASK = ~({LEN_DATA{1'b1}} << ALIGN_BITS);

  state_t              state;
  logic                pend_valid;
  logic [LEN_DATA-1:0] pend_addr;

  logic                req;
  logic                bad_align;
  logic                update;
  logic [LEN_DATA-1:0] req_raw;
  logic [LEN_DATA-1:0] req_addr;
  logic [LEN_DATA-1:0] next_pc;

  assign pc_plus_step = pc_out + PC_STEP;
  assign halted       = (state == HALT);

  always_comb begin
    req     = exc | jreg | branch | jump;
    req_raw = jump_addr;
    if (exc)         req_raw = EXC_VECTOR;
    else if (jreg)   req_raw = jreg_addr;
    else if (branch) req_raw = branch_addr;
    // The exception vector itself is trusted; only computed targets are checked.
    bad_align = req && !exc && ((req_raw & ALIGN_MASK) != '0);
    req_addr  = bad_align ? EXC_VECTOR : req_raw;
    update    = (state == STEP) || ((state == RUN) && !halt && !stall);
    if (req)             next_pc = req_addr;
    else if (pend_valid) next_pc = pend_addr;
    else                 next_pc = pc_plus_step;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      pc_out     <= RESET_PC;
      flush      <= 1'b0;
      misaligned <= 1'b0;
      upd_count  <= '0;
      pend_valid <= 1'b0;
      pend_addr  <= '0;
    end else begin
      misaligned <= bad_align;
      flush      <= update && (req || pend_valid);

      if (update) begin
        pc_out     <= next_pc;
        upd_count  <= upd_count + CNT_W'(1);
        pend_valid <= 1'b0;
      end else if (req) begin
        pend_valid <= 1'b1;
        pend_addr  <= req_addr;
      end

      // Step requests during a stall are dropped, not remembered.
      case (state)
        RUN:     if (halt) state <= HALT;
        HALT: begin
          if (!halt)               state <= RUN;
          else if (step && !stall) state <= STEP;
        end
        STEP:    state <= halt ? HALT : RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed table, hand-written halt/reset sequences,
// and random traffic compared each cycle against a cycle-level reference model.
module tb_pc_sequencer;

  localparam logic [31:0] EXC = 32'h80;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall, jump, branch, jreg, exc, halt, step;
  logic [31:0] jump_addr, branch_addr, jreg_addr;
  logic [31:0] pc_out, pc_plus_step, upd_count;
  logic        flush, misaligned, halted;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic        stall;
    logic        jump;
    logic [31:0] jump_addr;
    logic        branch;
    logic [31:0] branch_addr;
    logic        jreg;
    logic [31:0] jreg_addr;
    logic        exc;
    logic        halt;
    logic        step;
  } in_t;

  typedef struct {
    in_t         i;
    logic [31:0] pc;
    logic        fl;
    logic        mis;
    logic        hlt;
    logic [31:0] cnt;
  } vec_t;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .jump(jump), .jump_addr(jump_addr),
    .branch(branch), .branch_addr(branch_addr),
    .jreg(jreg), .jreg_addr(jreg_addr),
    .exc(exc), .halt(halt), .step(step),
    .pc_out(pc_out), .pc_plus_step(pc_plus_step), .flush(flush),
    .misaligned(misaligned), .halted(halted), .upd_count(upd_count)
  );

  always #5 clk = ~clk;

  // Reference model: the core is either running, halted, or carrying out one granted step.
  logic [31:0] m_pc, m_cnt;
  logic [31:0] m_pend[$];
  bit          m_flush, m_mis, m_halted, m_stepping;

  function automatic void model_reset();
    m_pc = 32'h0; m_cnt = 32'h0; m_pend.delete();
    m_flush = 0; m_mis = 0; m_halted = 0; m_stepping = 0;
  endfunction

  function automatic void model_step(input in_t v);
    bit          req, bad, upd;
    logic [31:0] tgt;
    req = v.exc || v.jreg || v.branch || v.jump;
    tgt = v.exc ? EXC : v.jreg ? v.jreg_addr : v.branch ? v.branch_addr : v.jump_addr;
    bad = req && !v.exc && (tgt % 4 != 0);
    if (bad) tgt = EXC;
    upd = m_stepping || (!m_halted && !v.halt && !v.stall);
    m_mis = bad;
    m_flush = 0;
    if (upd) begin
      m_cnt = m_cnt + 1;
      if (req) begin m_pc = tgt; m_flush = 1; end
      else if (m_pend.size() > 0) begin m_pc = m_pend[0]; m_flush = 1; end
      else m_pc = m_pc + 4;
      m_pend.delete();
    end else if (req) begin
      m_pend.delete();
      m_pend.push_back(tgt);
    end
    if (m_stepping) begin
      m_stepping = 0;
      m_halted = v.halt;
    end else if (m_halted) begin
      if (!v.halt) m_halted = 0;
      else if (v.step && !v.stall) m_stepping = 1;
    end else if (v.halt) begin
      m_halted = 1;
    end
  endfunction

  function automatic in_t vin(input logic s, input logic j, input logic [31:0] ja,
                              input logic b, input logic [31:0] ba,
                              input logic r, input logic [31:0] ra,
                              input logic e, input logic h, input logic st);
    in_t v;
    v.stall = s; v.jump = j; v.jump_addr = ja; v.branch = b; v.branch_addr = ba;
    v.jreg = r; v.jreg_addr = ra; v.exc = e; v.halt = h; v.step = st;
    return v;
  endfunction

  function automatic vec_t ve(input in_t i, input logic [31:0] pc, input logic fl,
                              input logic mis, input logic hlt, input logic [31:0] cnt);
    vec_t x;
    x.i = i; x.pc = pc; x.fl = fl; x.mis = mis; x.hlt = hlt; x.cnt = cnt;
    return x;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input in_t v);
    stall = v.stall; jump = v.jump; jump_addr = v.jump_addr;
    branch = v.branch; branch_addr = v.branch_addr;
    jreg = v.jreg; jreg_addr = v.jreg_addr;
    exc = v.exc; halt = v.halt; step = v.step;
  endtask

  // One clock: drive, advance the model, sample after the edge, compare against the model.
  task automatic tick(input in_t v);
    logic exp_h;
    drive(v);
    model_step(v);
    @(posedge clk);
    #1;
    exp_h = m_halted && !m_stepping;
    vectors++;
    if (pc_out !== m_pc || pc_plus_step !== m_pc + 32'd4 || flush !== m_flush ||
        misaligned !== m_mis || halted !== exp_h || upd_count !== m_cnt) begin
      miscompares++;
      $display("FAIL model t=%0t: got pc=%h pps=%h fl=%b mis=%b hlt=%b cnt=%0d expected pc=%h pps=%h fl=%b mis=%b hlt=%b cnt=%0d",
               $time, pc_out, pc_plus_step, flush, misaligned, halted, upd_count,
               m_pc, m_pc + 32'd4, m_flush, m_mis, exp_h, m_cnt);
    end
  endtask

  task automatic do_reset(input string tag);
    drive(vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1 rst_n = 1'b0;
    model_reset();
    #2;
    check({tag, "_pc"},     64'(pc_out),     64'h0);
    check({tag, "_halted"}, 64'(halted),     64'h0);
    check({tag, "_flush"},  64'(flush),      64'h0);
    check({tag, "_mis"},    64'(misaligned), 64'h0);
    check({tag, "_cnt"},    64'(upd_count),  64'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tbl[18];
  in_t  idle_v;

  initial begin
    idle_v = vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[0]  = ve(idle_v, 32'h4,  0, 0, 0, 1);
    tbl[1]  = ve(idle_v, 32'h8,  0, 0, 0, 2);
    tbl[2]  = ve(idle_v, 32'hC,  0, 0, 0, 3);
    tbl[3]  = ve(idle_v, 32'h10, 0, 0, 0, 4);
    tbl[4]  = ve(vin(0, 1, 32'h80, 1, 32'h40, 0, 0, 0, 0, 0), 32'h40, 1, 0, 0, 5);
    tbl[5]  = ve(idle_v, 32'h44, 0, 0, 0, 6);
    tbl[6]  = ve(vin(1, 0, 0, 1, 32'h100, 0, 0, 0, 0, 0), 32'h44, 0, 0, 0, 6);
    tbl[7]  = ve(vin(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 32'h44, 0, 0, 0, 6);
    tbl[8]  = ve(vin(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 32'h44, 0, 0, 0, 6);
    tbl[9]  = ve(idle_v, 32'h100, 1, 0, 0, 7);
    tbl[10] = ve(idle_v, 32'h104, 0, 0, 0, 8);
    tbl[11] = ve(vin(0, 0, 0, 0, 0, 1, 32'h102, 0, 0, 0), EXC, 1, 1, 0, 9);
    tbl[12] = ve(idle_v, 32'h84, 0, 0, 0, 10);
    tbl[13] = ve(vin(0, 0, 0, 0, 0, 1, 32'h3, 1, 0, 0), EXC, 1, 0, 0, 11);
    tbl[14] = ve(idle_v, 32'h84, 0, 0, 0, 12);
    tbl[15] = ve(vin(0, 1, 32'h200, 0, 0, 0, 0, 0, 1, 0), 32'h84, 0, 0, 1, 12);
    tbl[16] = ve(idle_v, 32'h84, 0, 0, 0, 12);
    tbl[17] = ve(idle_v, 32'h200, 1, 0, 0, 13);

    drive(idle_v);
    model_reset();
    #3;
    check("reset_pc",     64'(pc_out),       64'h0);
    check("reset_pps",    64'(pc_plus_step), 64'h4);
    check("reset_flush",  64'(flush),        64'h0);
    check("reset_mis",    64'(misaligned),   64'h0);
    check("reset_halted", 64'(halted),       64'h0);
    check("reset_cnt",    64'(upd_count),    64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 18; k++) begin
      tick(tbl[k].i);
      check($sformatf("tbl%0d_pc", k),     64'(pc_out),     64'(tbl[k].pc));
      check($sformatf("tbl%0d_flush", k),  64'(flush),      64'(tbl[k].fl));
      check($sformatf("tbl%0d_mis", k),    64'(misaligned), 64'(tbl[k].mis));
      check($sformatf("tbl%0d_halted", k), 64'(halted),     64'(tbl[k].hlt));
      check($sformatf("tbl%0d_cnt", k),    64'(upd_count),  64'(tbl[k].cnt));
    end

    // Halt at 0x20, single steps, and a step issued under stall that must be dropped.
    do_reset("rst_a");
    tick(vin(0, 1, 32'h20, 0, 0, 0, 0, 0, 0, 0));
    check("halt_start_pc", 64'(pc_out), 64'h20);
    tick(vin(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    check("halt_enter_pc", 64'(pc_out), 64'h20);
    check("halt_enter_h",  64'(halted), 64'h1);
    tick(vin(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    check("step1_grant_pc", 64'(pc_out), 64'h20);
    tick(vin(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    check("step1_pc",  64'(pc_out),    64'h24);
    check("step1_h",   64'(halted),    64'h1);
    check("step1_cnt", 64'(upd_count), 64'h2);
    tick(vin(1, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    tick(vin(1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tick(vin(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    check("stall_step_pc", 64'(pc_out), 64'h24);
    check("stall_step_h",  64'(halted), 64'h1);
    tick(vin(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    tick(vin(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    check("step2_pc",  64'(pc_out),    64'h28);
    check("step2_h",   64'(halted),    64'h1);
    check("step2_cnt", 64'(upd_count), 64'h3);

    // Reset while halted with a parked redirect, then PC wrap.
    tick(vin(0, 0, 0, 1, 32'h300, 0, 0, 0, 1, 0));
    check("park_pc", 64'(pc_out), 64'h28);
    do_reset("rst_b");
    tick(idle_v);
    check("post_rst_pc",    64'(pc_out), 64'h4);
    check("post_rst_flush", 64'(flush),  64'h0);
    tick(vin(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 0));
    check("wrap_top_pc",  64'(pc_out),       64'hFFFF_FFFC);
    check("wrap_top_pps", 64'(pc_plus_step), 64'h0);
    tick(idle_v);
    check("wrap_pc",    64'(pc_out), 64'h0);
    check("wrap_flush", 64'(flush),  64'h0);
    check("wrap_cnt",   64'(upd_count), 64'h3);

    // Random traffic against the model.
    begin
      in_t v;
      bit  hl;
      hl = 0;
      for (int n = 0; n < 1500; n++) begin
        if ($urandom % 20 == 0) hl = !hl;
        v.stall       = ($urandom % 4 == 0);
        v.jump        = ($urandom % 8 == 0);
        v.branch      = ($urandom % 8 == 0);
        v.jreg        = ($urandom % 10 == 0);
        v.exc         = ($urandom % 25 == 0);
        v.halt        = hl;
        v.step        = ($urandom % 3 == 0);
        v.jump_addr   = $urandom;
        v.branch_addr = $urandom;
        v.jreg_addr   = $urandom;
        if ($urandom % 4 != 0) v.jump_addr[1:0] = 2'b00;
        if ($urandom % 4 != 0) v.branch_addr[1:0] = 2'b00;
        if ($urandom % 4 != 0) v.jreg_addr[1:0] = 2'b00;
        tick(v);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
